// File: rtl/assoc_cache_memory.sv
// assoc_cache_memory: 2-way set-associative write-back/write-allocate cache, LRU replacement, req/ack backing memory, whole-cache flush
//   processor: reqValid/reqReady/reqWrite/reqAddr/reqData -> rspValid/rspData/hit; control: flushStart -> flushDone, busy
//   memory: memReq/memWrite/memAddr/memWData -> memAck/memRData
module assoc_cache_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              clrN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              hit,
  input  logic              flushStart,
  output logic              flushDone,
  output logic              busy,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData
);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int SETS  = 1 << IDX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, FILL, RESP, FL_SCAN, FL_WB} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d, mem_wdata_q, mem_wdata_d, wr_data;
  logic wr_q, wr_d, vic_q, vic_d, rsp_valid_q, rsp_valid_d, hit_q, hit_d, flush_done_q, flush_done_d;
  logic mem_req_q, mem_req_d, mem_write_q, mem_write_d, we, we_way, adv;
  logic [IDX_W:0] ent_q, ent_d;
  logic [SETS-1:0][1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0] lru_q, lru_d;
  logic [TAG_W-1:0] tag_mem [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS];
  logic [IDX_W-1:0] idx, fidx, wb_idx;
  logic [TAG_W-1:0] tag;
  logic hit0, hit1, hway, vway, fway, wb_way;
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];
  assign fidx = ent_q[IDX_W:1];
  assign fway = ent_q[0];
  assign hit0 = valid_q[idx][0] && tag_mem[0][idx] == tag;
  assign hit1 = valid_q[idx][1] && tag_mem[1][idx] == tag;
  assign hway = !hit0;
  assign vway = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  // Miss eviction and flush share one write-back path; only the entry being written back differs
  assign wb_idx = state_q == FL_WB ? fidx : idx;
  assign wb_way = state_q == FL_WB ? fway : vic_q;
  assign reqReady = state_q == IDLE && !flushStart;
  assign busy = state_q != IDLE;
  assign rspValid = rsp_valid_q;
  assign rspData = rsp_data_q;
  assign hit = hit_q;
  assign flushDone = flush_done_q;
  assign memReq = mem_req_q;
  assign memWrite = mem_write_q;
  assign memAddr = mem_addr_q;
  assign memWData = mem_wdata_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wr_d = wr_q;
    wdata_d = wdata_q;
    vic_d = vic_q;
    ent_d = ent_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    lru_d = lru_q;
    rsp_data_d = rsp_data_q;
    mem_req_d = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    hit_d = 1'b0;
    flush_done_d = 1'b0;
    we = 1'b0;
    we_way = vic_q;
    wr_data = wdata_q;
    adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (flushStart) begin
          state_d = FL_SCAN;
          ent_d = '0;
        end else if (reqValid) begin
          state_d = LOOKUP;
          addr_d = reqAddr;
          wr_d = reqWrite;
          wdata_d = reqData;
        end
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
          hit_d = 1'b1;
          lru_d[idx] = !hway;
          rsp_data_d = wr_q ? wdata_q : data_mem[hway][idx];
          we = wr_q;
          we_way = hway;
          if (wr_q) dirty_d[idx][hway] = 1'b1;
        end else begin
          vic_d = vway;
          state_d = dirty_q[idx][vway] ? WBACK : FILL;
        end
      end
      WBACK, FL_WB: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          mem_write_d = 1'b1;
          mem_addr_d = {tag_mem[wb_way][wb_idx], wb_idx};
          mem_wdata_d = data_mem[wb_way][wb_idx];
        end else if (memAck) begin
          mem_req_d = 1'b0;
          dirty_d[wb_idx][wb_way] = 1'b0;
          adv = state_q == FL_WB;
          if (state_q == WBACK) state_d = FILL;
        end
      end
      FILL: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d = addr_q;
        end else if (memAck) begin
          mem_req_d = 1'b0;
          we = 1'b1;
          wr_data = wr_q ? wdata_q : memRData;
          valid_d[idx][vic_q] = 1'b1;
          dirty_d[idx][vic_q] = wr_q;
          lru_d[idx] = !vic_q;
          rsp_data_d = wr_q ? wdata_q : memRData;
          rsp_valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      FL_SCAN: begin
        if (dirty_q[fidx][fway]) state_d = FL_WB;
        else adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      ent_d = ent_q + {{IDX_W{1'b0}}, 1'b1};
      state_d = &ent_q ? IDLE : FL_SCAN;
      flush_done_d = &ent_q;
    end
  end
  always_ff @(posedge clk or negedge clrN)
    if (!clrN) begin
      state_q <= IDLE;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      vic_q <= 1'b0;
      ent_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q <= '0;
      rsp_data_q <= '0;
      rsp_valid_q <= 1'b0;
      hit_q <= 1'b0;
      flush_done_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      vic_q <= vic_d;
      ent_q <= ent_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q <= lru_d;
      rsp_data_q <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      hit_q <= hit_d;
      flush_done_q <= flush_done_d;
      mem_req_q <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  always_ff @(posedge clk)
    if (we) begin
      tag_mem[we_way][idx] <= tag;
      data_mem[we_way][idx] <= wr_data;
    end
endmodule

// File: tb/tb_assoc_cache_memory.sv
// tb_assoc_cache_memory: directed self-checking bench for assoc_cache_memory with a variable-latency backing memory
module tb_assoc_cache_memory;
  logic clk = 1'b0, clrN = 1'b0;
  logic reqValid = 1'b0, reqWrite = 1'b0, flushStart = 1'b0, memAck;
  logic [7:0] reqAddr = '0, reqData = '0, memRData;
  logic reqReady, rspValid, hit, flushDone, busy, memReq, memWrite;
  logic [7:0] rspData, memAddr, memWData;
  logic [7:0] bmem [256];
  logic txn_w [$];
  logic [7:0] txn_a [$];
  logic [7:0] txn_d [$];
  int checks = 0, failures = 0, ack_lat = 3, req_cyc = 0, cnt = 0;

  assoc_cache_memory dut (
    .clk(clk), .clrN(clrN), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqData(reqData), .rspValid(rspValid), .rspData(rspData), .hit(hit),
    .flushStart(flushStart), .flushDone(flushDone), .busy(busy), .memReq(memReq),
    .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData), .memAck(memAck), .memRData(memRData)
  );

  always #5 clk = ~clk;

  initial begin
    memAck = 1'b0;
    memRData = '0;
    forever begin
      @(posedge clk); #1;
      if (memReq) req_cyc++;
      if (memAck) memAck = 1'b0;
      else if (memReq && clrN) begin
        cnt++;
        if (cnt >= ack_lat) begin
          cnt = 0;
          memAck = 1'b1;
          txn_w.push_back(memWrite);
          txn_a.push_back(memAddr);
          txn_d.push_back(memWData);
          if (memWrite) bmem[memAddr] = memWData;
          else memRData = bmem[memAddr];
        end
      end else cnt = 0;
    end
  end

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic h, output int lat);
    int n;
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d;
    n = 0;
    while (!reqReady && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 200) begin @(posedge clk); #1; lat++; end
    rd = rspData;
    h = hit;
    checks++;
    if (rspValid !== 1'b1) begin failures++; $display("FAIL rsp_timeout addr=%h got rspValid=%b exp=1", a, rspValid); end
  endtask

  task automatic do_flush(output int bc, output logic fd);
    int n;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    flushStart = 1'b1;
    @(posedge clk); #1;
    flushStart = 1'b0;
    bc = 0;
    fd = 1'b0;
    while (busy && bc < 2000) begin bc++; fd = fd | flushDone; @(posedge clk); #1; end
    fd = fd | flushDone;
  endtask

  task automatic test_reset;
    clrN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rspValid, hit, flushDone, memReq, memWrite, busy, reqReady} !== 7'b0000001) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000001", {rspValid, hit, flushDone, memReq, memWrite, busy, reqReady});
    end
    checks++;
    if (memAddr !== 8'h00) begin failures++; $display("FAIL reset_memAddr got=%h exp=00", memAddr); end
    checks++;
    if (memWData !== 8'h00) begin failures++; $display("FAIL reset_memWData got=%h exp=00", memWData); end
    checks++;
    if (rspData !== 8'h00) begin failures++; $display("FAIL reset_rspData got=%h exp=00", rspData); end
    clrN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_hit;
    logic [7:0] rd;
    logic h;
    logic [8:0] e;
    int lat, n0, r0;
    bmem[8'h13] = 8'hA5;
    n0 = txn_a.size();
    do_req(1'b0, 8'h13, 8'h00, rd, h, lat);
    checks++;
    if (rd !== 8'hA5) begin failures++; $display("FAIL miss_rd got=%h exp=a5", rd); end
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL miss_hit got=%b exp=0", h); end
    checks++;
    if (txn_a.size() != n0 + 1) begin failures++; $display("FAIL miss_txn_count got=%0d exp=%0d", txn_a.size() - n0, 1); end
    e = txn_a.size() > n0 ? {txn_w[n0], txn_a[n0]} : 9'h1ff;
    checks++;
    if (e !== 9'h013) begin failures++; $display("FAIL miss_fill got=%h exp=013", e); end
    r0 = req_cyc;
    do_req(1'b0, 8'h13, 8'h00, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h1A5) begin failures++; $display("FAIL rehit got=%h exp=1a5", {h, rd}); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL rehit_latency got=%0d exp=2", lat); end
    checks++;
    if (req_cyc != r0) begin failures++; $display("FAIL rehit_memreq got=%0d exp=0", req_cyc - r0); end
  endtask

  task automatic test_evict_writeback;
    logic [7:0] rd;
    logic h;
    logic [16:0] e;
    int lat, n0;
    bmem[8'h0B] = 8'h3C;
    bmem[8'h23] = 8'hC3;
    do_req(1'b1, 8'h13, 8'h5A, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h15A) begin failures++; $display("FAIL wr_hit got=%h exp=15a", {h, rd}); end
    n0 = txn_a.size();
    do_req(1'b0, 8'h0B, 8'h00, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h03C) begin failures++; $display("FAIL fill_way1 got=%h exp=03c", {h, rd}); end
    checks++;
    if (txn_a.size() != n0 + 1) begin failures++; $display("FAIL fill_way1_txn got=%0d exp=1", txn_a.size() - n0); end
    n0 = txn_a.size();
    do_req(1'b0, 8'h23, 8'h00, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h0C3) begin failures++; $display("FAIL evict_rd got=%h exp=0c3", {h, rd}); end
    checks++;
    if (txn_a.size() != n0 + 2) begin failures++; $display("FAIL evict_txn_count got=%0d exp=2", txn_a.size() - n0); end
    e = txn_a.size() > n0 ? {txn_w[n0], txn_a[n0], txn_d[n0]} : 17'h1ffff;
    checks++;
    if (e !== 17'h1135A) begin failures++; $display("FAIL evict_wb got=%h exp=1135a", e); end
    e = txn_a.size() > n0 + 1 ? {txn_w[n0+1], txn_a[n0+1], 8'h00} : 17'h1ffff;
    checks++;
    if (e !== 17'h02300) begin failures++; $display("FAIL evict_fill got=%h exp=02300", e); end
  endtask

  task automatic test_write_miss_flush;
    logic [7:0] rd;
    logic h, fd;
    logic [16:0] e;
    int lat, n0, bc;
    bmem[8'h40] = 8'h11;
    n0 = txn_a.size();
    do_req(1'b1, 8'h40, 8'h77, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h077) begin failures++; $display("FAIL wmiss_rsp got=%h exp=077", {h, rd}); end
    e = txn_a.size() == n0 + 1 ? {txn_w[n0], txn_a[n0], 8'h00} : 17'h1ffff;
    checks++;
    if (e !== 17'h04000) begin failures++; $display("FAIL wmiss_fill got=%h exp=04000", e); end
    do_req(1'b0, 8'h40, 8'h00, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h177) begin failures++; $display("FAIL wmiss_reread got=%h exp=177", {h, rd}); end
    n0 = txn_a.size();
    do_flush(bc, fd);
    checks++;
    if (fd !== 1'b1) begin failures++; $display("FAIL dirty_flush_done got=%b exp=1", fd); end
    checks++;
    if (txn_a.size() != n0 + 1) begin failures++; $display("FAIL dirty_flush_count got=%0d exp=1", txn_a.size() - n0); end
    e = txn_a.size() > n0 ? {txn_w[n0], txn_a[n0], txn_d[n0]} : 17'h1ffff;
    checks++;
    if (e !== 17'h14077) begin failures++; $display("FAIL dirty_flush_wb got=%h exp=14077", e); end
  endtask

  task automatic test_flush_clean;
    logic fd;
    int bc, r0;
    r0 = req_cyc;
    do_flush(bc, fd);
    checks++;
    if (bc != 16) begin failures++; $display("FAIL clean_flush_busy got=%0d exp=16", bc); end
    checks++;
    if (fd !== 1'b1) begin failures++; $display("FAIL clean_flush_done got=%b exp=1", fd); end
    checks++;
    if (req_cyc != r0) begin failures++; $display("FAIL clean_flush_memreq got=%0d exp=0", req_cyc - r0); end
    @(posedge clk); #1;
    checks++;
    if (flushDone !== 1'b0) begin failures++; $display("FAIL flushdone_pulse got=%b exp=0", flushDone); end
  endtask

  task automatic test_flush_priority;
    logic [7:0] rd;
    logic h;
    int lat, bc;
    flushStart = 1'b1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 8'h40;
    #1;
    checks++;
    if (reqReady !== 1'b0) begin failures++; $display("FAIL prio_reqReady got=%b exp=0", reqReady); end
    @(posedge clk); #1;
    flushStart = 1'b0;
    bc = 0;
    while (busy && bc < 2000) begin bc++; @(posedge clk); #1; end
    checks++;
    if (bc != 16) begin failures++; $display("FAIL prio_flush_busy got=%0d exp=16", bc); end
    do_req(1'b0, 8'h40, 8'h00, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h177) begin failures++; $display("FAIL prio_req_after got=%h exp=177", {h, rd}); end
  endtask

  task automatic test_reset_mid_fill;
    logic [7:0] rd;
    logic h;
    logic [8:0] e;
    int lat, n, n0;
    bmem[8'h55] = 8'h66;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    ack_lat = 20;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 8'h55;
    @(posedge clk); #1;
    reqValid = 1'b0;
    n = 0;
    while (!memReq && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (memReq !== 1'b1) begin failures++; $display("FAIL midfill_memreq_rise got=%b exp=1", memReq); end
    #2;
    clrN = 1'b0;
    #1;
    checks++;
    if ({memReq, busy, rspValid} !== 3'b000) begin failures++; $display("FAIL midfill_abort got=%b exp=000", {memReq, busy, rspValid}); end
    @(posedge clk); #1;
    clrN = 1'b1;
    ack_lat = 3;
    @(posedge clk); #1;
    n0 = txn_a.size();
    do_req(1'b0, 8'h55, 8'h00, rd, h, lat);
    checks++;
    if ({h, rd} !== 9'h066) begin failures++; $display("FAIL post_reset_miss got=%h exp=066", {h, rd}); end
    e = txn_a.size() == n0 + 1 ? {txn_w[n0], txn_a[n0]} : 9'h1ff;
    checks++;
    if (e !== 9'h055) begin failures++; $display("FAIL post_reset_fill got=%h exp=055", e); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
    test_reset;
    test_read_miss_hit;
    test_evict_writeback;
    test_write_miss_flush;
    test_flush_clean;
    test_flush_priority;
    test_reset_mid_fill;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/assoc_cache_memory.md
Name: assoc_cache_memory

Overview:
Parametrised successor to the direct-mapped cache/RAM memory module. It is a 2-way set-associative, write-back, write-allocate cache with LRU replacement. It connects to an external backing memory through a variable-latency req/ack handshake, and provides a whole-cache flush. It sits between the processor datapath and the backing RAM.

Parameters:
DATA_W, 8, data word width; one word per line
ADDR_W, 8, word address width
IDX_W, 3, set index width; sets = 2**IDX_W; tag width TAG_W = ADDR_W-IDX_W (IDX_W < ADDR_W)

Ports:
clk  in  1  system clock, rising edge
clrN  in  1  asynchronous active-low reset
reqValid  in  1  processor request present
reqReady  out  1  high iff state IDLE and flushStart low; transfer on reqValid&reqReady
reqWrite  in  1  1=write, 0=read
reqAddr  in  ADDR_W  word address
reqData  in  DATA_W  write data
rspValid  out  1  one-cycle pulse: read data valid / write complete
rspData  out  DATA_W  read data; for writes, the written word
hit  out  1  one-cycle pulse with rspValid when the request hit
flushStart  in  1  start flush, sampled only in IDLE
flushDone  out  1  one-cycle pulse at flush completion
busy  out  1  high whenever state != IDLE
memReq  out  1  backing-memory request, held until memAck
memWrite  out  1  1=write-back, 0=fill; stable while memReq
memAddr  out  ADDR_W  {tag,index}; stable while memReq
memWData  out  DATA_W  write-back data; stable while memReq
memAck  in  1  one-cycle completion pulse; any latency >=1 cycle
memRData  in  DATA_W  fill data, valid with memAck when memWrite=0

Behaviour:
- Reset (clrN low, async): state IDLE; every valid, dirty and lru bit cleared; rspValid, hit, flushDone, memReq, memWrite = 0; memAddr, memWData, rspData = 0. Tag/data arrays are not reset. Reset mid-operation abandons it: memReq drops immediately, no rspValid.
- Request registers (addr, write, data) are captured on the acceptance edge.
- States: IDLE, LOOKUP, WBACK, FILL, RESP, FL_SCAN, FL_WB.
- IDLE -> FL_SCAN on flushStart. Flush has priority: reqReady is forced low that cycle, so no request is accepted.
- IDLE -> LOOKUP on reqValid&reqReady.
- LOOKUP compares both ways' valid+tag.
  - Hit -> RESP. Read returns the way's data. Write updates data and sets dirty. lru[set] = other way.
  - Miss, victim selection: invalid way0, else invalid way1, else way lru[set].
  - Miss with victim dirty -> WBACK; otherwise -> FILL.
- WBACK: memReq=1, memWrite=1, memAddr={victim tag,idx}, memWData=victim data. On memAck: clear dirty -> FILL.
- FILL: memReq=1, memWrite=0, memAddr=request addr. On memAck: victim way gets tag, data=memRData, valid=1, dirty=0; lru[set] = other way.
  - Read miss: response data = memRData.
  - Write miss: data = reqData, dirty=1, response data = reqData.
  - Then -> RESP.
- memReq rises the cycle after entering WBACK/FILL and is low the cycle after memAck. memAck is ignored when memReq is low.
- RESP: rspValid=1 for exactly one cycle; hit=1 only if the LOOKUP hit; -> IDLE.
- Latency from acceptance edge: hit = rspValid 2 cycles later. Miss = memory round trip(s) plus 2 control cycles.
- FL_SCAN walks set 0..2**IDX_W-1, way0 then way1, one entry per cycle.
  - Dirty entry -> FL_WB (write-back as in WBACK). On memAck: dirty=0, valid kept, resume at next entry.
  - After the last entry: flushDone=1 for one cycle -> IDLE.
  - Flush with no dirty lines takes exactly 2*2**IDX_W cycles.
- lru, valid and dirty are flop arrays; tag/data arrays may be flop or RAM with combinational read.

Test Plan:
- Reset, read 0x13 (memAck 3 cycles after memReq, memRData=0xA5) -> one fill at memAddr 0x13, rspData=0xA5, hit=0. Re-read 0x13 -> rspValid 2 cycles after accept, hit=1, no memReq.
- Write 0x13=0x5A (hit) to dirty it, then read 0x0B (same set 3, fills way1), then read 0x23 (set 3, LRU=way0) -> write-back memAddr=0x13 memWData=0x5A, then fill 0x23.
- Write miss 0x40=0x77 -> fill read of 0x40 issued; rspData=0x77. Read 0x40 -> 0x77, hit=1. Flush -> exactly one write-back (0x40, 0x77).
- Flush with clean cache (IDX_W=3) -> busy 16 cycles, flushDone pulse, no memReq.
- flushStart and reqValid high in the same IDLE cycle -> reqReady=0, flush runs, request accepted after flushDone.
- clrN low while memReq high in FILL -> memReq=0 immediately. Next read of the same addr misses (valid cleared).
